dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the byte-addressed data memory.
//  Port 0 is the pipeline MEM stage and port 1 is the loader/DMA engine.
//  Grants at most one access per cycle, range/alignment-checks it, drives the memory
//  WE/A/WD bus, and returns a registered response tagged to the granted requester.
// PARAMETERS
//  DATA_WIDTH   32        data/address width
//  BASE_ADDR    32'h10000 first valid data-memory byte address
//  MEM_BYTES    2**17     size of the valid window in bytes
//  MAX_WAIT     4         cycles port 1 may be refused while pending before forced grant (1..15)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  p0_valid     in   1   port 0 request valid
//  p0_ready     out  1   port 0 request accepted this cycle (comb.)
//  p0_op        in   2   00 rd word, 01 wr word, 10 rd byte (zero-ext), 11 wr byte
//  p0_addr      in   32  byte address
//  p0_wdata     in   32  write data (byte ops use [7:0])
//  p1_valid/p1_ready/p1_op/p1_addr/p1_wdata   same as port 0, for requester 1
//  rsp_valid    out  1   response pulse, one cycle after acceptance
//  rsp_id       out  1   requester the response belongs to
//  rsp_err      out  1   access rejected (out of range or misaligned)
//  rsp_rdata    out  32  read data (0 for writes and errors)
//  mem_we       out  2   memory WE (00 none, 01 word, 10 byte-read mode, 11 byte write)
//  mem_a        out  32  memory byte address
//  mem_wd       out  32  memory write data
//  mem_rd       in   32  memory combinational read data
// BEHAVIOUR
//  Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_err=0, rsp_rdata=0,
//   wait_cnt=0, state=P0_PRIO. Readies and mem_* are combinational; with no valid, mem_we=00 and mem_a=0.
//  FSM (2 states):
//   P0_PRIO:   p0_valid wins; else p1_valid wins.
//    Each cycle p1_valid=1 and p1 is not granted: wait_cnt++.
//    wait_cnt==MAX_WAIT-1 with another refusal -> STARVED.
//   STARVED:   p1 is granted unconditionally if p1_valid, and p0_ready=0.
//    Then wait_cnt=0 and state -> P0_PRIO. If p1_valid drops, also -> P0_PRIO.
//  Any p1 grant clears wait_cnt. p1_valid=0 holds wait_cnt.
//  Exactly one of p0_ready/p1_ready may be 1 in a cycle; ready never asserts without valid.
//  Grant cycle: mem_a=addr and mem_wd=wdata of the winner. mem_we = op for writes.
//   Byte read drives 10; word read drives 00.
//  Error check (comb., on the winner):
//   addr<BASE_ADDR, or addr+size>BASE_ADDR+MEM_BYTES (size 4 word, 1 byte), or word op with addr[1:0]!=0.
//   On error: mem_we forced 00 (no write), the request is still accepted, rsp_err=1.
//  Response (registered, latency 1): on the edge after acceptance, rsp_valid=1.
//   rsp_id=winner; rsp_err as checked.
//   rsp_rdata=mem_rd for word read, {24'b0,mem_rd[7:0]} for byte read, 0 otherwise.
//   Next cycle with no acceptance: rsp_valid=0, other rsp_* hold.
//  Back-to-back: one acceptance per cycle sustained, responses in order.
//  Write-then-read to the same addr on consecutive cycles returns the new data, because the memory writes on the edge.
//  Address arithmetic: range check in 33 bits so addr near 2^32 cannot wrap into range.
//  Reset mid-operation: a pending response is dropped (rsp_valid=0); the memory write already issued stands.
//  Requesters must hold op/addr/wdata stable while valid && !ready.
// TESTING
//  T1: p0 wr word 0x10000=0xDEADBEEF, then p0 rd word 0x10000
//      -> rsp_valid cycles +1,+2; rdata 0xDEADBEEF, id=0, err=0.
//  T2: p0 and p1 both valid for 6 cycles, MAX_WAIT=4
//      -> grants p0,p0,p0,p0,p1,p0; wait_cnt 1,2,3,4->0.
//  T3: p1 wr byte 0x10003=0xA5, then rd byte -> rdata 0x000000A5.
//      A word read at 0x10000 returns 0xA5 in bits [31:24].
//  T4: p0 rd word 0x10002 (misaligned), and 0x0FFFF / 0x30000 (out of range)
//      -> rsp_err=1, rdata=0, mem_we=00 each time.
//  T5: assert rst_n=0 the cycle after an accepted read -> rsp_valid=0 immediately.
//      After release, arbiter is in P0_PRIO with wait_cnt=0.
//  T6: p1 alone valid continuously -> granted every cycle, wait_cnt stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter in front of the byte-addressed data memory.
//   Port 0 (pipeline MEM stage) normally has priority. Port 1 (loader/DMA) is
//   guaranteed a grant after MAX_WAIT consecutive refusals. The winning request
//   is range/alignment checked, driven onto the memory bus, and answered with a
//   registered response one cycle later.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   p0_valid/p0_ready/p0_op/        port 0 request handshake; op: 00 rd word,
//   p0_addr/p0_wdata                01 wr word, 10 rd byte, 11 wr byte
//   p1_*                            same for port 1
//   rsp_valid/rsp_id/rsp_err/       registered response, tagged with requester
//   rsp_rdata
//   mem_we/mem_a/mem_wd             memory control (00 none, 01 word write,
//                                   10 byte-read mode, 11 byte write)
//   mem_rd                          combinational memory read data
module dmem_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 'h10000,
  parameter int                    MEM_BYTES  = 2**17,
  parameter int                    MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [1:0]            p0_op,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [1:0]            p1_op,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic {P0_PRIO = 1'b0, STARVED = 1'b1} state_t;

  // Range limits carried one bit wider than the address so that an address
  // near the top of the space cannot wrap back into the valid window.
  localparam logic [DATA_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [DATA_WIDTH:0] LIMIT_EXT = BASE_EXT + (DATA_WIDTH+1)'(MEM_BYTES);
  localparam logic [3:0]          WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t                state_reg;
  logic [3:0]            wait_cnt_reg;

  logic                  grant_p0;
  logic                  grant_p1;
  logic                  accept;
  logic [1:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH:0]   addr_ext;
  logic [DATA_WIDTH:0]   end_ext;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rdata_next;

  // Grant decision: in STARVED port 0 is locked out entirely.
  always_comb begin
    grant_p0 = (state_reg == P0_PRIO) && p0_valid;
    grant_p1 = (state_reg == STARVED) ? p1_valid : (!p0_valid && p1_valid);
    accept   = grant_p0 || grant_p1;
  end

  assign p0_ready = grant_p0;
  assign p1_ready = grant_p1;

  // Winner mux; all zero when nothing is granted.
  always_comb begin
    sel_op    = 2'b00;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant_p1) begin
      sel_op    = p1_op;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end else if (grant_p0) begin
      sel_op    = p0_op;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end
  end

  // op[1] marks a byte access (size 1), otherwise a word (size 4).
  always_comb begin
    addr_ext = {1'b0, sel_addr};
    end_ext  = addr_ext + (sel_op[1] ? (DATA_WIDTH+1)'(1) : (DATA_WIDTH+1)'(4));
    acc_err  = accept &&
               ((addr_ext < BASE_EXT) || (end_ext > LIMIT_EXT) ||
                (!sel_op[1] && (sel_addr[1:0] != 2'b00)));
  end

  // A rejected access still goes through the handshake but never touches memory.
  assign mem_we = (accept && !acc_err) ? sel_op : 2'b00;
  assign mem_a  = sel_addr;
  assign mem_wd = sel_wdata;

  always_comb begin
    rdata_next = '0;
    if (!acc_err && !sel_op[0]) begin
      if (sel_op[1]) rdata_next = {{(DATA_WIDTH-8){1'b0}}, mem_rd[7:0]};
      else           rdata_next = mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= P0_PRIO;
      wait_cnt_reg <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      case (state_reg)
        P0_PRIO: begin
          if (grant_p1) begin
            wait_cnt_reg <= 4'd0;
          end else if (p1_valid) begin
            // ">=" rather than "==" so a count left high after p1 dropped out
            // of STARVED still escalates on the next refusal.
            if (wait_cnt_reg >= WAIT_LAST) state_reg <= STARVED;
            if (wait_cnt_reg != 4'hF) wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        STARVED: begin
          if (p1_valid) wait_cnt_reg <= 4'd0;
          state_reg <= P0_PRIO;
        end
        default: state_reg <= P0_PRIO;
      endcase

      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grant_p1;
        rsp_err   <= acc_err;
        rsp_rdata <= rdata_next;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h10000;
  localparam int          NBYTES = 131072;

  logic        clk;
  logic        rst_n;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [1:0]  p0_op, p1_op;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_op(p0_op),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_op(p1_op),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory covering the valid window.
  logic [7:0] mem_arr [0:NBYTES-1];
  initial for (int i = 0; i < NBYTES; i++) mem_arr[i] = 8'h00;

  always_comb begin
    int unsigned off;
    off    = mem_a - BASE;
    mem_rd = 32'h0;
    if (mem_we == 2'b10) begin
      if (off < NBYTES) mem_rd = {24'h0, mem_arr[off]};
    end else if (off + 3 < NBYTES) begin
      mem_rd = {mem_arr[off+3], mem_arr[off+2], mem_arr[off+1], mem_arr[off]};
    end
  end

  always @(posedge clk) begin
    int unsigned off;
    off = mem_a - BASE;
    if (mem_we == 2'b01 && off + 3 < NBYTES) begin
      mem_arr[off]   = mem_wd[7:0];
      mem_arr[off+1] = mem_wd[15:8];
      mem_arr[off+2] = mem_wd[23:16];
      mem_arr[off+3] = mem_wd[31:24];
    end else if (mem_we == 2'b11 && off < NBYTES) begin
      mem_arr[off] = mem_wd[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation for every response pulse.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (rst_n && mon_en && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_id"},    {31'h0, rsp_id},  {31'h0, e.id});
        chk({e.name, "_err"},   {31'h0, rsp_err}, {31'h0, e.err});
        chk({e.name, "_rdata"}, rsp_rdata,        e.rdata);
        $display("rsp %-10s id=%0d err=%0d rdata=0x%08h", e.name, rsp_id, rsp_err, rsp_rdata);
      end
    end
  end

  // One cycle of stimulus. exp_g: 0 none, 1 port 0, 2 port 1.
  task automatic issue(input bit v0, input logic [1:0] op0, input logic [31:0] a0,
                       input logic [31:0] d0, input bit v1, input logic [1:0] op1,
                       input logic [31:0] a1, input logic [31:0] d1, input int exp_g,
                       input logic [1:0] exp_we, input bit exp_err,
                       input logic [31:0] exp_rd, input string name);
    exp_t e;
    logic [31:0] exp_a;
    @(negedge clk);
    p0_valid = v0; p0_op = op0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_op = op1; p1_addr = a1; p1_wdata = d1;
    #1;
    chk({name, "_grant"}, {30'h0, p1_ready, p0_ready},
        (exp_g == 1) ? 32'd1 : (exp_g == 2) ? 32'd2 : 32'd0);
    chk({name, "_we"}, {30'h0, mem_we}, {30'h0, exp_we});
    exp_a = (exp_g == 1) ? a0 : (exp_g == 2) ? a1 : 32'h0;
    chk({name, "_a"}, mem_a, exp_a);
    $display("req %-10s p0r=%0d p1r=%0d we=%b a=0x%08h", name, p0_ready, p1_ready, mem_we, mem_a);
    if (exp_g != 0) begin
      e.id = (exp_g == 2); e.err = exp_err; e.rdata = exp_rd; e.name = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input string name);
    issue(0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 0, 32'h0, name);
  endtask

  initial begin
    rst_n = 1'b0;
    p0_valid = 0; p0_op = 0; p0_addr = 0; p0_wdata = 0;
    p1_valid = 0; p1_op = 0; p1_addr = 0; p1_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", {30'h0, mem_we}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // T1: word write then word read of the same address.
    issue(1, 2'b01, 32'h10000, 32'hDEADBEEF, 0, 2'b00, 32'h0, 32'h0, 1, 2'b01, 0, 32'h0, "t1_wr");
    issue(1, 2'b00, 32'h10000, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 0, 32'hDEADBEEF, "t1_rd");
    idle("t1_idle");

    // T2: both valid for 6 cycles; port 1 forced through on the 5th.
    for (int i = 0; i < 6; i++)
      issue(1, 2'b00, 32'h10000, 32'h0, 1, 2'b00, 32'h10004, 32'h0,
            (i == 4) ? 2 : 1, 2'b00, 0, (i == 4) ? 32'h0 : 32'hDEADBEEF, $sformatf("t2_%0d", i));

    // T3: byte write/read on port 1, then word view of the modified word.
    issue(0, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h10003, 32'h000000A5, 2, 2'b11, 0, 32'h0, "t3_wrb");
    issue(0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'h10003, 32'h0, 2, 2'b10, 0, 32'h000000A5, "t3_rdb");
    issue(0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 32'h10000, 32'h0, 2, 2'b00, 0, 32'hA5ADBEEF, "t3_rdw");

    // T4: errors (misaligned, below, above, wrap) and in-range boundaries.
    issue(1, 2'b00, 32'h10002, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 1, 32'h0, "t4_misal");
    issue(1, 2'b00, 32'h0FFFF, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 1, 32'h0, "t4_low");
    issue(1, 2'b00, 32'h30000, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 1, 32'h0, "t4_high");
    issue(1, 2'b11, 32'h30000, 32'h55, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 1, 32'h0, "t4_wrbhi");
    issue(1, 2'b01, 32'hFFFFFFFC, 32'h1, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 1, 32'h0, "t4_wrap");
    issue(1, 2'b01, 32'h2FFFC, 32'h12345678, 0, 2'b00, 32'h0, 32'h0, 1, 2'b01, 0, 32'h0, "t4_wrtop");
    issue(1, 2'b10, 32'h2FFFF, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 0, 32'h00000012, "t4_rdbtop");
    issue(1, 2'b00, 32'h2FFFC, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 0, 32'h12345678, "t4_rdtop");

    // T6: port 1 alone is granted every cycle and never builds up a wait count.
    for (int i = 0; i < 5; i++)
      issue(0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 32'h10000, 32'h0, 2, 2'b00, 0, 32'hA5ADBEEF,
            $sformatf("t6_%0d", i));
    for (int i = 0; i < 5; i++)
      issue(1, 2'b00, 32'h10004, 32'h0, 1, 2'b00, 32'h10000, 32'h0,
            (i == 4) ? 2 : 1, 2'b00, 0, (i == 4) ? 32'hA5ADBEEF : 32'h0, $sformatf("t6b_%0d", i));

    // T5: build up a wait count, accept a read, then reset right after the edge.
    issue(1, 2'b00, 32'h10004, 32'h0, 1, 2'b00, 32'h10000, 32'h0, 1, 2'b00, 0, 32'h0, "t5_a");
    issue(1, 2'b00, 32'h10004, 32'h0, 1, 2'b00, 32'h10000, 32'h0, 1, 2'b00, 0, 32'h0, "t5_b");
    issue(1, 2'b00, 32'h10000, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, 0, 32'hA5ADBEEF, "t5_rd");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("t5_rsp_rdata", rsp_rdata, 32'h0);
    exp_q.delete();   // the pending response is intentionally dropped by reset
    p0_valid = 0; p1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      issue(1, 2'b00, 32'h10004, 32'h0, 1, 2'b00, 32'h10000, 32'h0,
            (i == 4) ? 2 : 1, 2'b00, 0, (i == 4) ? 32'hA5ADBEEF : 32'h0, $sformatf("t5_post%0d", i));

    idle("end_idle0");
    idle("end_idle1");
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
